tval_trap_writer: RTL and testbench

//  Consumer end of the trap-value path. Accepts one committed trap from the ROB
//  and waits TVAL_DELAY cycles so the tval selector has settled. It then samples
//  the published tval, writes it to mtval or stval through a valid/ready CSR

---
 rtl/tval_trap_writer_pkg.sv | 32 +++
 rtl/tval_trap_writer_if.sv | 46 ++++
 rtl/tval_trap_writer.sv | 116 +++++++++++
 tb/tb_tval_trap_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tval_trap_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tval_trap_writer_pkg
//  Purpose  : Shared types for the trap-value write path: sequence-number
//             type, trap FSM states, latched trap request and CSR selects.
//  Revision : 1.0  initial release
// ============================================================================
package tval_trap_writer_pkg;

  localparam int SQN_W = 7;

  typedef logic [SQN_W-1:0] SqN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    FIRE  = 2'd3
  } TrapState_t;

  typedef struct packed {
    SqN         sqN;
    logic [4:0] cause;
    logic       toS;
    logic       tvalUse;
  } TrapReq;

  localparam logic CSR_SEL_MTVAL = 1'b0;
  localparam logic CSR_SEL_STVAL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tval_trap_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tval_trap_writer_if
//  Purpose  : Bundle of ROB commit, tval selector, abort and CSR write-port
//             signals around the trap-value writer. The slave modport is the
//             writer itself; master is its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface tval_trap_writer_if #(
  parameter int SQN_W = 7
);

  logic             IN_trapValid;
  logic [SQN_W-1:0] IN_trapSqN;
  logic [4:0]       IN_trapCause;
  logic             IN_trapToS;
  logic             IN_tvalUse;
  logic [31:0]      IN_tval;
  logic             IN_abort;
  logic             IN_csrWrReady;

  logic             OUT_stall;
  logic             OUT_csrWrValid;
  logic             OUT_csrWrSel;
  logic [31:0]      OUT_csrWrData;
  logic             OUT_trapFire;
  logic [4:0]       OUT_trapCause;
  logic             OUT_trapToS;
  logic [SQN_W-1:0] OUT_trapSqN;

  modport slave (
    input  IN_trapValid, IN_trapSqN, IN_trapCause, IN_trapToS, IN_tvalUse,
           IN_tval, IN_abort, IN_csrWrReady,
    output OUT_stall, OUT_csrWrValid, OUT_csrWrSel, OUT_csrWrData,
           OUT_trapFire, OUT_trapCause, OUT_trapToS, OUT_trapSqN
  );

  modport master (
    output IN_trapValid, IN_trapSqN, IN_trapCause, IN_trapToS, IN_tvalUse,
           IN_tval, IN_abort, IN_csrWrReady,
    input  OUT_stall, OUT_csrWrValid, OUT_csrWrSel, OUT_csrWrData,
           OUT_trapFire, OUT_trapCause, OUT_trapToS, OUT_trapSqN
  );

endinterface
`default_nettype wire

// File: rtl/tval_trap_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tval_trap_writer
//  Purpose  : Accepts one committed trap, waits TVAL_DELAY cycles for the tval
//             selector to settle, samples tval once, writes it to mtval/stval
//             over a valid/ready port, then pulses the trap-fire strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tval_trap_writer
  import tval_trap_writer_pkg::*;
#(
  parameter int SQN_W      = 7,
  parameter int TVAL_DELAY = 2   // legal range 1..7
) (
  input wire clk,
  input wire rst,
  tval_trap_writer_if.slave bus
);

  localparam int CNT_W = $clog2(TVAL_DELAY + 1);

  TrapState_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  TrapReq           req_q,   req_d;
  logic [31:0]      data_q,  data_d;

  // State, counter, request latch and data register; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: accept, count down to the sample point, write, fire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        // Abort is meaningless here and must not mask a new trap.
        if (bus.IN_trapValid) begin
          req_d.sqN     = SqN'(bus.IN_trapSqN);
          req_d.cause   = bus.IN_trapCause;
          req_d.toS     = bus.IN_trapToS;
          req_d.tvalUse = bus.IN_tvalUse;
          cnt_d         = CNT_W'(TVAL_DELAY - 1);
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (bus.IN_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // Single sample point; later tval changes never reach data_q.
          data_d  = req_q.tvalUse ? bus.IN_tval : 32'd0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        // Once valid is raised it stays up until the CSR unit takes it.
        if (bus.IN_csrWrReady) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from state only; data outputs are zero outside their window.
  always_comb begin
    bus.OUT_stall      = (state_q != IDLE);
    bus.OUT_csrWrValid = 1'b0;
    bus.OUT_csrWrSel   = CSR_SEL_MTVAL;
    bus.OUT_csrWrData  = 32'd0;
    bus.OUT_trapFire   = 1'b0;
    bus.OUT_trapCause  = 5'd0;
    bus.OUT_trapToS    = 1'b0;
    bus.OUT_trapSqN    = '0;
    if (state_q == WRITE) begin
      bus.OUT_csrWrValid = 1'b1;
      bus.OUT_csrWrSel   = req_q.toS ? CSR_SEL_STVAL : CSR_SEL_MTVAL;
      bus.OUT_csrWrData  = data_q;
    end
    if (state_q == FIRE) begin
      bus.OUT_trapFire  = 1'b1;
      bus.OUT_trapCause = req_q.cause;
      bus.OUT_trapToS   = req_q.toS;
      bus.OUT_trapSqN   = SQN_W'(req_q.sqN);
    end
  end

  // Commit must hold off while a trap is in flight.
  a_no_trap_while_busy: assert property (@(posedge clk) disable iff (rst)
    !((state_q != IDLE) && bus.IN_trapValid))
    else $error("trap presented while writer busy");

endmodule
`default_nettype wire

// File: tb/tb_tval_trap_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tval_trap_writer
//  Purpose  : Self-checking bench for tval_trap_writer. Each scenario is
//             described by its commit values, a per-cycle ready pattern and
//             an optional abort cycle; expected outputs per cycle come from
//             the timing rules (sample at commit+D, write until first ready,
//             fire one cycle later).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tval_trap_writer;

  localparam int D     = 2;
  localparam int SQN_W = 7;

  typedef struct packed {
    logic        stall;
    logic        wr_valid;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        fire;
    logic [4:0]  cause;
    logic        tos;
    logic [6:0]  sqn;
  } obs_t;

  logic clk;
  logic rst;

  tval_trap_writer_if #(.SQN_W(SQN_W)) bus ();

  tval_trap_writer #(.SQN_W(SQN_W), .TVAL_DELAY(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Scenario description
  logic [6:0]  sc_sqn;
  logic [4:0]  sc_cause;
  logic        sc_tos;
  logic        sc_use;
  logic [31:0] sc_tval;
  int          sc_abort_k;
  bit          rdy [0:31];
  int          sc_w;
  int          sc_last;

  // Derive the write-completion cycle and the scenario length.
  task automatic plan();
    int w;
    w = D + 1;
    while (!rdy[w] && w < 31) w++;
    sc_w = w;
    if (sc_abort_k >= 1 && sc_abort_k <= D) sc_last = sc_abort_k + 1;
    else                                    sc_last = sc_w + 2;
  endtask

  task automatic fill_rdy(bit v);
    for (int i = 0; i < 32; i++) rdy[i] = v;
    rdy[31] = 1'b1;
  endtask

  // Expected outputs in cycle k (k = 0 is the commit cycle).
  function automatic obs_t model_cycle(int k);
    obs_t e;
    e = '0;
    if (sc_abort_k >= 1 && sc_abort_k <= D) begin
      e.stall = (k >= 1 && k <= sc_abort_k);
    end else begin
      e.stall = (k >= 1 && k <= sc_w + 1);
      if (k >= D + 1 && k <= sc_w) begin
        e.wr_valid = 1'b1;
        e.wr_sel   = sc_tos;
        e.wr_data  = sc_use ? sc_tval : 32'd0;
      end
      if (k == sc_w + 1) begin
        e.fire  = 1'b1;
        e.cause = sc_cause;
        e.tos   = sc_tos;
        e.sqn   = sc_sqn;
      end
    end
    return e;
  endfunction

  function automatic obs_t observe();
    return {bus.OUT_stall, bus.OUT_csrWrValid, bus.OUT_csrWrSel,
            bus.OUT_csrWrData, bus.OUT_trapFire, bus.OUT_trapCause,
            bus.OUT_trapToS, bus.OUT_trapSqN};
  endfunction

  // Inputs for cycle k; fields outside their meaningful cycle carry noise.
  task automatic drive_cycle(int k);
    bus.IN_trapValid  = (k == 0);
    bus.IN_trapSqN    = (k == 0) ? sc_sqn   : 7'($urandom);
    bus.IN_trapCause  = (k == 0) ? sc_cause : 5'($urandom);
    bus.IN_trapToS    = (k == 0) ? sc_tos   : 1'($urandom);
    bus.IN_tvalUse    = (k == 0) ? sc_use   : 1'($urandom);
    bus.IN_tval       = (k == D) ? sc_tval  : $urandom;
    bus.IN_abort      = (k == sc_abort_k);
    bus.IN_csrWrReady = rdy[k];
  endtask

  task automatic drive_idle();
    bus.IN_trapValid  = 1'b0;
    bus.IN_trapSqN    = '0;
    bus.IN_trapCause  = '0;
    bus.IN_trapToS    = 1'b0;
    bus.IN_tvalUse    = 1'b0;
    bus.IN_tval       = '0;
    bus.IN_abort      = 1'b0;
    bus.IN_csrWrReady = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    drive_idle();
    bus.IN_trapValid = 1'b1;
    bus.IN_tval      = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    got = observe();
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_held got=%h exp=0", got);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = observe();
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=0", got);
    end
  endtask

  task automatic test_basic();
    obs_t got, exp;
    sc_sqn = 7'd5; sc_cause = 5'd13; sc_tos = 1'b0; sc_use = 1'b1;
    sc_tval = 32'hDEAD_BEEF; sc_abort_k = -1;
    fill_rdy(1'b1);
    plan();
    for (int k = 0; k <= sc_last; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_no_tval();
    obs_t got, exp;
    sc_sqn = 7'd77; sc_cause = 5'd2; sc_tos = 1'b1; sc_use = 1'b0;
    sc_tval = 32'h0000_1234; sc_abort_k = -1;
    fill_rdy(1'b1);
    plan();
    for (int k = 0; k <= sc_last; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL no_tval k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_ready_stall();
    obs_t got, exp;
    sc_sqn = 7'd99; sc_cause = 5'd7; sc_tos = 1'b1; sc_use = 1'b1;
    sc_tval = 32'hA5C3_0F1E; sc_abort_k = -1;
    fill_rdy(1'b1);
    for (int i = D + 1; i <= D + 5; i++) rdy[i] = 1'b0;
    plan();
    for (int k = 0; k <= sc_last; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ready_stall k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_abort_wait();
    obs_t got, exp;
    sc_sqn = 7'd3; sc_cause = 5'd15; sc_tos = 1'b0; sc_use = 1'b1;
    sc_tval = 32'h1111_2222; sc_abort_k = 1;
    fill_rdy(1'b1);
    plan();
    for (int k = 0; k <= sc_last + 4; k++) begin
      @(negedge clk);
      if (k <= sc_last) drive_cycle(k);
      else              drive_idle();
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_wait k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_abort_write();
    obs_t got, exp;
    sc_sqn = 7'd64; sc_cause = 5'd5; sc_tos = 1'b1; sc_use = 1'b1;
    sc_tval = 32'hCAFE_F00D; sc_abort_k = D + 2;
    fill_rdy(1'b1);
    for (int i = D + 1; i <= D + 3; i++) rdy[i] = 1'b0;
    plan();
    for (int k = 0; k <= sc_last; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_write k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t got, exp;
    sc_sqn = 7'd42; sc_cause = 5'd12; sc_tos = 1'b0; sc_use = 1'b1;
    sc_tval = 32'h0BAD_CAFE; sc_abort_k = -1;
    fill_rdy(1'b0);
    plan();
    for (int k = 0; k <= D + 2; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_write_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      bus.IN_csrWrReady = 1'b1;
      got = observe();
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL rst_write_post j=%0d got=%h exp=0", j, got);
      end
    end
    sc_sqn = 7'd17; sc_cause = 5'd1; sc_tos = 1'b1; sc_use = 1'b1;
    sc_tval = 32'h5566_7788; sc_abort_k = -1;
    fill_rdy(1'b1);
    rdy[D + 1] = 1'b0;
    plan();
    for (int k = 0; k <= sc_last; k++) begin
      @(negedge clk);
      drive_cycle(k);
      exp = model_cycle(k);
      got = observe();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_write_after k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    for (int t = 0; t < 40; t++) begin
      sc_sqn   = 7'($urandom);
      sc_cause = 5'($urandom);
      sc_tos   = 1'($urandom);
      sc_use   = ($urandom_range(0, 3) != 0);
      sc_tval  = $urandom;
      sc_abort_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, D + 5)) : -1;
      fill_rdy(1'b0);
      for (int i = 0; i <= D + 8; i++) rdy[i] = ($urandom_range(0, 2) == 0);
      rdy[D + 9] = 1'b1;
      plan();
      for (int k = 0; k <= sc_last; k++) begin
        @(negedge clk);
        drive_cycle(k);
        exp = model_cycle(k);
        got = observe();
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random t=%0d k=%0d got=%h exp=%h", t, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive_idle();
    test_reset();
    test_basic();
    test_no_tval();
    test_ready_stall();
    test_abort_wait();
    test_abort_write();
    test_reset_mid_write();
    test_random();
    @(negedge clk);
    drive_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
